// File: rtl/tmr_voter_seq_pkg.sv
// Shared definitions for the TMR voter: channel health FSM encoding and a
// generic bitwise-majority helper sized for up to MAX_CH channels of MAX_W bits.
package tmr_voter_seq_pkg;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAULTY  = 2'd2
  } chan_state_e;

  localparam int MAX_W    = 64;
  localparam int MAX_CH   = 7;
  localparam int MAX_BITS = MAX_W * MAX_CH;

  // Channel c occupies data[c*width +: width]; callers zero-extend into MAX_BITS.
  function automatic logic [MAX_W-1:0] majority(input logic [MAX_BITS-1:0] data,
                                                input int n_ch, input int width);
    logic [MAX_W-1:0] res;
    int ones;
    res = '0;
    for (int b = 0; b < width; b++) begin
      ones = 0;
      for (int c = 0; c < n_ch; c++) begin
        if (data[c*width + b]) ones++;
      end
      res[b] = (ones > n_ch / 2);
    end
    return res;
  endfunction

endpackage

// File: rtl/tmr_voter_seq_chan_monitor.sv
// Per-channel health tracker: OK -> SUSPECT -> FAULTY on consecutive
// mismatching valid beats; FAULTY is sticky until clr.
module tmr_chan_monitor
  import tmr_voter_seq_pkg::*;
#(
  parameter int FAULT_THRESH = 3,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic        mismatch,
  input  logic        clr,
  output logic        fault,
  output chan_state_e state
);

  chan_state_e      state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_OK;
      cnt_q <= '0;
    end else begin
      state <= state_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt_q;
    if (clr) begin
      state_d = ST_OK;
      cnt_d   = '0;
    end else if (valid) begin
      unique case (state)
        ST_OK: begin
          if (mismatch) begin
            cnt_d   = CNT_W'(1);
            state_d = (FAULT_THRESH == 1) ? ST_FAULTY : ST_SUSPECT;
          end
        end
        ST_SUSPECT: begin
          if (mismatch) begin
            cnt_d = sat_inc(cnt_q);
            if (int'(cnt_q) + 1 == FAULT_THRESH) state_d = ST_FAULTY;
          end else begin
            cnt_d   = '0;
            state_d = ST_OK;
          end
        end
        ST_FAULTY: ;
        default: begin
          state_d = ST_OK;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign fault = (state == ST_FAULTY);

endmodule

// File: rtl/tmr_voter_seq.sv
// Registered N-way bitwise majority voter with per-channel fault tracking.
// Optional macro TMR_VOTER_FAULT_MASK_EN excludes faulty channels from out_data/agree.
module tmr_voter_seq
  import tmr_voter_seq_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int N_CH         = 3,
  parameter int FAULT_THRESH = 3,
  parameter int CNT_W        = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic                  clr_fault,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic                  agree,
  output logic [N_CH-1:0]       mismatch,
  output logic [N_CH-1:0]       fault
);

  logic [WIDTH-1:0] maj_p0;
  logic [WIDTH-1:0] vote_p0;
  logic [N_CH-1:0]  mm_p0;
  logic             agree_p0;
  logic             hold_p0;
  logic [N_CH-1:0]  chan_fault;
  chan_state_e      chan_state [N_CH];

  // Stage p0: unmasked majority and per-channel disagreement
  assign maj_p0 = WIDTH'(majority(MAX_BITS'(in_data), N_CH, WIDTH));

  always_comb begin
    mm_p0 = '0;
    for (int c = 0; c < N_CH; c++) begin
      mm_p0[c] = (in_data[c*WIDTH +: WIDTH] != maj_p0);
    end
  end

`ifdef TMR_VOTER_FAULT_MASK_EN
  int               ones;
  int               hc;
  logic [WIDTH-1:0] ref_w;

  always_comb begin
    vote_p0  = maj_p0;
    agree_p0 = 1'b1;
    hold_p0  = 1'b0;
    ones     = 0;
    hc       = 0;
    ref_w    = '0;
    if (&chan_fault) begin
      hold_p0 = 1'b1;
    end else begin
      // Descending scan leaves the lowest-index healthy word as the tie-break reference.
      for (int c = N_CH - 1; c >= 0; c--) begin
        if (!chan_fault[c]) ref_w = in_data[c*WIDTH +: WIDTH];
      end
      for (int c = 0; c < N_CH; c++) begin
        if (!chan_fault[c] && (in_data[c*WIDTH +: WIDTH] != ref_w)) agree_p0 = 1'b0;
      end
      for (int b = 0; b < WIDTH; b++) begin
        ones = 0;
        hc   = 0;
        for (int c = 0; c < N_CH; c++) begin
          if (!chan_fault[c]) begin
            hc++;
            if (in_data[c*WIDTH + b]) ones++;
          end
        end
        vote_p0[b] = (2 * ones > hc) ? 1'b1 : (2 * ones < hc) ? 1'b0 : ref_w[b];
      end
    end
  end
`else
  always_comb begin
    vote_p0  = maj_p0;
    agree_p0 = (mm_p0 == '0);
    hold_p0  = 1'b0;
  end
`endif

  // Stage p1: registered outputs; reset discards any in-flight beat
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      agree     <= 1'b0;
      mismatch  <= '0;
    end else if (in_valid) begin
      out_valid <= 1'b1;
      if (!hold_p0) out_data <= vote_p0;
      agree     <= agree_p0;
      mismatch  <= mm_p0;
    end else begin
      out_valid <= 1'b0;
      mismatch  <= '0;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_mon
    tmr_chan_monitor #(
      .FAULT_THRESH(FAULT_THRESH),
      .CNT_W       (CNT_W)
    ) u_mon (
      .clk     (clk),
      .rst     (rst),
      .valid   (in_valid),
      .mismatch(mm_p0[i]),
      .clr     (clr_fault),
      .fault   (chan_fault[i]),
      .state   (chan_state[i])
    );

    a_fault_state : assert property (@(posedge clk) chan_fault[i] == (chan_state[i] == ST_FAULTY));
  end

  assign fault = chan_fault;

endmodule
